// File: rtl/awg_ctrl_pkg.sv
// Shared state encoding, default widths and output reset values for the
// waveform configuration scheduler.
package awg_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_SWEEP
   } sched_state_t;

   localparam int unsigned ADDER_W_DEF = 32;
   localparam int unsigned DWELL_W_DEF = 16;

   localparam logic [7:0] RST_SIGNAL_NUMBER = 8'h00;
   localparam logic [7:0] RST_AMPLITUDE     = 8'h00;
   localparam logic       RST_SWEEP_ACTIVE  = 1'b0;
   localparam logic       RST_SWEEP_DONE    = 1'b0;
   localparam logic       RST_CFG_READY     = 1'b1;

endpackage

// File: rtl/sweep_step_unit.sv
// Dwell timer and saturating next-increment computation for the frequency sweep.
module sweep_step_unit #(
   parameter int unsigned ADDER_W = 32,
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               restart,
   input  logic [ADDER_W-1:0] adder,
   input  logic [ADDER_W-1:0] step,
   input  logic [ADDER_W-1:0] stop,
   input  logic [DWELL_W-1:0] dwell,
   output logic               step_due,
   output logic [ADDER_W-1:0] next_adder,
   output logic               at_stop
);

   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] last;
   logic [ADDER_W:0]   sum;

   // A dwell of zero behaves as one cycle; cnt counts visible cycles minus one.
   assign last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         cnt <= '0;
      end else if (cnt < last) begin
         cnt <= cnt + DWELL_W'(1);
      end
   end

   assign step_due   = (cnt >= last);
   assign sum        = {1'b0, adder} + {1'b0, step};
   assign next_adder = (sum[ADDER_W] || (sum[ADDER_W-1:0] >= stop)) ? stop : sum[ADDER_W-1:0];
   assign at_stop    = (adder >= stop);

endmodule

// File: rtl/waveform_config_scheduler.sv
// Accepts waveform configurations, commits them at a phase wrap and runs an
// optional linear adder sweep; owns the live registers read by the DDS.
module waveform_config_scheduler
   import awg_ctrl_pkg::*;
#(
   parameter int unsigned ADDER_W = ADDER_W_DEF,
   parameter int unsigned DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [7:0]         cfg_signal_number,
   input  logic [7:0]         cfg_amplitude,
   input  logic [ADDER_W-1:0] cfg_adder_start,
   input  logic [ADDER_W-1:0] cfg_adder_stop,
   input  logic [ADDER_W-1:0] cfg_adder_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_sweep_en,
   input  logic               cfg_sweep_loop,
   input  logic               phase_wrap,
   output logic [7:0]         signalNumber,
   output logic [ADDER_W-1:0] adder,
   output logic [7:0]         amplitude,
   output logic               sweep_active,
   output logic               sweep_done
);

   sched_state_t state, state_nx;

   logic [7:0]         sh_num, sh_amp;
   logic [ADDER_W-1:0] sh_start, sh_stop, sh_step;
   logic [DWELL_W-1:0] sh_dwell;
   logic               sh_sweep_en, sh_loop;

   logic [7:0]         num_nx, amp_nx;
   logic [ADDER_W-1:0] adder_nx;
   logic               active_nx, done_nx, ready_nx;

   logic               accept, adder_load, sweep_ok;
   logic               step_due, at_stop;
   logic [ADDER_W-1:0] next_adder;

   assign accept   = cfg_valid && cfg_ready;
   assign sweep_ok = sh_sweep_en && (sh_step != '0) && (sh_start < sh_stop);

   sweep_step_unit #(
      .ADDER_W (ADDER_W),
      .DWELL_W (DWELL_W)
   ) u_step (
      .clk        (clk),
      .reset      (reset),
      .restart    ((state != ST_SWEEP) || adder_load),
      .adder      (adder),
      .step       (sh_step),
      .stop       (sh_stop),
      .dwell      (sh_dwell),
      .step_due   (step_due),
      .next_adder (next_adder),
      .at_stop    (at_stop)
   );

   always_comb begin
      state_nx   = state;
      num_nx     = signalNumber;
      amp_nx     = amplitude;
      adder_nx   = adder;
      active_nx  = sweep_active;
      done_nx    = 1'b0;
      adder_load = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept) state_nx = ST_PENDING;
         end
         ST_PENDING: begin
            // A zero increment never wraps, so commit without waiting.
            if (phase_wrap || (adder == '0)) begin
               num_nx     = sh_num;
               amp_nx     = sh_amp;
               adder_nx   = sh_start;
               adder_load = 1'b1;
               if (sweep_ok) begin
                  state_nx  = ST_SWEEP;
                  active_nx = 1'b1;
               end else begin
                  state_nx  = ST_IDLE;
               end
            end
         end
         ST_SWEEP: begin
            // A new configuration takes priority over any due step.
            if (accept) begin
               state_nx  = ST_PENDING;
               active_nx = 1'b0;
            end else if (step_due && phase_wrap) begin
               if (!at_stop) begin
                  adder_nx   = next_adder;
                  adder_load = 1'b1;
               end else if (sh_loop) begin
                  adder_nx   = sh_start;
                  adder_load = 1'b1;
               end else begin
                  state_nx  = ST_IDLE;
                  active_nx = 1'b0;
                  done_nx   = 1'b1;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      ready_nx = (state_nx != ST_PENDING);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         signalNumber <= RST_SIGNAL_NUMBER;
         amplitude    <= RST_AMPLITUDE;
         adder        <= '0;
         sweep_active <= RST_SWEEP_ACTIVE;
         sweep_done   <= RST_SWEEP_DONE;
         cfg_ready    <= RST_CFG_READY;
         sh_num       <= '0;
         sh_amp       <= '0;
         sh_start     <= '0;
         sh_stop      <= '0;
         sh_step      <= '0;
         sh_dwell     <= '0;
         sh_sweep_en  <= 1'b0;
         sh_loop      <= 1'b0;
      end else begin
         state        <= state_nx;
         signalNumber <= num_nx;
         amplitude    <= amp_nx;
         adder        <= adder_nx;
         sweep_active <= active_nx;
         sweep_done   <= done_nx;
         cfg_ready    <= ready_nx;
         if (accept) begin
            sh_num      <= cfg_signal_number;
            sh_amp      <= cfg_amplitude;
            sh_start    <= cfg_adder_start;
            sh_stop     <= cfg_adder_stop;
            sh_step     <= cfg_adder_step;
            sh_dwell    <= cfg_dwell;
            sh_sweep_en <= cfg_sweep_en;
            sh_loop     <= cfg_sweep_loop;
         end
      end
   end

endmodule

// File: tb/tb_waveform_config_scheduler.sv
// Self-checking bench for waveform_config_scheduler: directed scenarios plus
// randomized sweeps compared against a cycle-level behavioural model.
module tb_waveform_config_scheduler;

   localparam int unsigned ADDER_W = 32;
   localparam int unsigned DWELL_W = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [7:0]         cfg_signal_number;
   logic [7:0]         cfg_amplitude;
   logic [ADDER_W-1:0] cfg_adder_start;
   logic [ADDER_W-1:0] cfg_adder_stop;
   logic [ADDER_W-1:0] cfg_adder_step;
   logic [DWELL_W-1:0] cfg_dwell;
   logic               cfg_sweep_en;
   logic               cfg_sweep_loop;
   logic               phase_wrap;
   logic [7:0]         signalNumber;
   logic [ADDER_W-1:0] adder;
   logic [7:0]         amplitude;
   logic               sweep_active;
   logic               sweep_done;

   int checks = 0;
   int errors = 0;

   waveform_config_scheduler #(
      .ADDER_W (ADDER_W),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .cfg_valid         (cfg_valid),
      .cfg_ready         (cfg_ready),
      .cfg_signal_number (cfg_signal_number),
      .cfg_amplitude     (cfg_amplitude),
      .cfg_adder_start   (cfg_adder_start),
      .cfg_adder_stop    (cfg_adder_stop),
      .cfg_adder_step    (cfg_adder_step),
      .cfg_dwell         (cfg_dwell),
      .cfg_sweep_en      (cfg_sweep_en),
      .cfg_sweep_loop    (cfg_sweep_loop),
      .phase_wrap        (phase_wrap),
      .signalNumber      (signalNumber),
      .adder             (adder),
      .amplitude         (amplitude),
      .sweep_active      (sweep_active),
      .sweep_done        (sweep_done)
   );

   always #5 clk = ~clk;

   // Snapshot layout: {signalNumber, amplitude, adder, sweep_active, sweep_done, cfg_ready}
   function automatic logic [50:0] pack(input logic [7:0] n, input logic [7:0] a,
                                        input logic [31:0] ad, input logic act,
                                        input logic dn, input logic rdy);
      return {n, a, ad, act, dn, rdy};
   endfunction

   function automatic logic [50:0] outs();
      return {signalNumber, amplitude, adder, sweep_active, sweep_done, cfg_ready};
   endfunction

   // Sweep step rule: add, and clamp to stop on overflow or reaching stop.
   function automatic longint unsigned step_rule(input longint unsigned cur,
                                                 input longint unsigned stp,
                                                 input longint unsigned stop);
      longint unsigned n;
      n = cur + stp;
      return (n >= stop) ? stop : n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [7:0] n, input logic [7:0] a, input logic [31:0] st,
                          input logic [31:0] sp, input logic [31:0] stp, input logic [15:0] dw,
                          input logic en, input logic lp);
      cfg_signal_number = n;
      cfg_amplitude     = a;
      cfg_adder_start   = st;
      cfg_adder_stop    = sp;
      cfg_adder_step    = stp;
      cfg_dwell         = dw;
      cfg_sweep_en      = en;
      cfg_sweep_loop    = lp;
   endtask

   task automatic test_reset();
      reset = 1'b1; cfg_valid = 1'b0; phase_wrap = 1'b0;
      set_cfg(8'h00, 8'h00, 32'h0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0);
      repeat (3) tick();
      reset = 1'b0;
      tick();
      checks++;
      if (outs() !== pack(8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1)) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", outs(), pack(8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1));
      end
   endtask

   task automatic test_immediate_commit();
      set_cfg(8'd2, 8'h80, 32'h1000, 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      checks++;
      if (outs() !== pack(8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL imm_pending got=%h exp=%h", outs(), pack(8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0));
      end
      tick();
      checks++;
      if (outs() !== pack(8'd2, 8'h80, 32'h1000, 1'b0, 1'b0, 1'b1)) begin
         errors++;
         $display("FAIL imm_commit got=%h exp=%h", outs(), pack(8'd2, 8'h80, 32'h1000, 1'b0, 1'b0, 1'b1));
      end
   endtask

   task automatic test_commit_waits_wrap();
      set_cfg(8'd3, 8'h40, 32'h2000, 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);
      cfg_valid = 1'b1;
      tick();
      // Keep offering a different configuration: it must stall while pending.
      set_cfg(8'd9, 8'h99, 32'h9999, 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);
      for (int i = 0; i < 50; i++) begin
         checks++;
         if (outs() !== pack(8'd2, 8'h80, 32'h1000, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL wrap_wait cyc=%0d got=%h exp=%h", i, outs(), pack(8'd2, 8'h80, 32'h1000, 1'b0, 1'b0, 1'b0));
         end
         tick();
      end
      cfg_valid  = 1'b0;
      phase_wrap = 1'b1;
      tick();
      phase_wrap = 1'b0;
      checks++;
      if (outs() !== pack(8'd3, 8'h40, 32'h2000, 1'b0, 1'b0, 1'b1)) begin
         errors++;
         $display("FAIL wrap_commit got=%h exp=%h", outs(), pack(8'd3, 8'h40, 32'h2000, 1'b0, 1'b0, 1'b1));
      end
      repeat (3) tick();
      checks++;
      if (outs() !== pack(8'd3, 8'h40, 32'h2000, 1'b0, 1'b0, 1'b1)) begin
         errors++;
         $display("FAIL wrap_stall_dropped got=%h exp=%h", outs(), pack(8'd3, 8'h40, 32'h2000, 1'b0, 1'b0, 1'b1));
      end
   endtask

   task automatic test_one_shot_sweep();
      logic [31:0] pts [4];
      pts[0] = 32'd100; pts[1] = 32'd200; pts[2] = 32'd300; pts[3] = 32'd350;
      phase_wrap = 1'b1;
      set_cfg(8'd1, 8'h10, 32'd100, 32'd350, 32'd100, 16'd4, 1'b1, 1'b0);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tick();
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (outs() !== pack(8'd1, 8'h10, pts[k/4], 1'b1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL oneshot cyc=%0d got=%h exp=%h", k, outs(), pack(8'd1, 8'h10, pts[k/4], 1'b1, 1'b0, 1'b1));
         end
         tick();
      end
      checks++;
      if (outs() !== pack(8'd1, 8'h10, 32'd350, 1'b0, 1'b1, 1'b1)) begin
         errors++;
         $display("FAIL oneshot_done got=%h exp=%h", outs(), pack(8'd1, 8'h10, 32'd350, 1'b0, 1'b1, 1'b1));
      end
      tick();
      checks++;
      if (outs() !== pack(8'd1, 8'h10, 32'd350, 1'b0, 1'b0, 1'b1)) begin
         errors++;
         $display("FAIL oneshot_after got=%h exp=%h", outs(), pack(8'd1, 8'h10, 32'd350, 1'b0, 1'b0, 1'b1));
      end
   endtask

   task automatic test_overflow_loop();
      logic [31:0] exp_ad;
      phase_wrap = 1'b1;
      set_cfg(8'd4, 8'h20, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 16'd2, 1'b1, 1'b1);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tick();
      for (int k = 0; k < 8; k++) begin
         exp_ad = ((k / 2) % 2 == 1) ? 32'hFFFF_FFFF : 32'hFFFF_FF00;
         checks++;
         if (outs() !== pack(8'd4, 8'h20, exp_ad, 1'b1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL loop cyc=%0d got=%h exp=%h", k, outs(), pack(8'd4, 8'h20, exp_ad, 1'b1, 1'b0, 1'b1));
         end
         tick();
      end
   endtask

   // Continues the looping sweep: now on the first cycle of 0xFFFF_FF00.
   task automatic test_accept_beats_step_then_reset();
      tick();
      checks++;
      if (outs() !== pack(8'd4, 8'h20, 32'hFFFF_FF00, 1'b1, 1'b0, 1'b1)) begin
         errors++;
         $display("FAIL abs_due got=%h exp=%h", outs(), pack(8'd4, 8'h20, 32'hFFFF_FF00, 1'b1, 1'b0, 1'b1));
      end
      set_cfg(8'd7, 8'h77, 32'h5555, 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);
      cfg_valid = 1'b1;
      tick();
      cfg_valid  = 1'b0;
      phase_wrap = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (outs() !== pack(8'd4, 8'h20, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL abs_pending cyc=%0d got=%h exp=%h", i, outs(), pack(8'd4, 8'h20, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b0));
         end
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (outs() !== pack(8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1)) begin
         errors++;
         $display("FAIL abs_reset got=%h exp=%h", outs(), pack(8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1));
      end
      for (int i = 0; i < 4; i++) begin
         phase_wrap = 1'(i % 2);
         tick();
         checks++;
         if (outs() !== pack(8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL abs_discarded cyc=%0d got=%h exp=%h", i, outs(), pack(8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1));
         end
      end
      phase_wrap = 1'b0;
   endtask

   task automatic test_random_sweeps();
      longint unsigned start, stop, stp, cur, dmin, base;
      logic [7:0]      n, a;
      logic [15:0]     dw;
      logic            en, lp, act, dn, w;
      int              age;
      for (int it = 0; it < 10; it++) begin
         reset = 1'b1; cfg_valid = 1'b0; phase_wrap = 1'b0;
         tick();
         reset = 1'b0;
         base  = (it % 3 == 2) ? 64'hFFFF_F000 : 64'h0;
         start = base + $urandom_range(1, 2000);
         stp   = (it % 3 == 2) ? $urandom_range(1, 4096) : $urandom_range(1, 300);
         if ($urandom_range(0, 7) == 0) stp = 0;
         stop  = start + stp * $urandom_range(0, 3) + $urandom_range(1, 300);
         if (stop > 64'hFFFF_FFFF) stop = 64'hFFFF_FFFF;
         if ($urandom_range(0, 7) == 0) stop = start;
         n  = 8'($urandom_range(0, 255));
         a  = 8'($urandom_range(0, 255));
         dw = 16'($urandom_range(0, 5));
         en = ($urandom_range(0, 4) != 0);
         lp = 1'($urandom_range(0, 1));
         set_cfg(n, a, start[31:0], stop[31:0], stp[31:0], dw, en, lp);
         cfg_valid = 1'b1;
         tick();
         cfg_valid = 1'b0;
         tick();
         cur  = start;
         act  = en && (stp != 0) && (start < stop);
         dn   = 1'b0;
         age  = 1;
         dmin = (dw == 16'd0) ? 1 : longint'(dw);
         for (int cyc = 0; cyc < 120; cyc++) begin
            checks++;
            if (outs() !== pack(n, a, cur[31:0], act, dn, 1'b1)) begin
               errors++;
               $display("FAIL rand_sweep it=%0d cyc=%0d got=%h exp=%h", it, cyc, outs(), pack(n, a, cur[31:0], act, dn, 1'b1));
            end
            w = 1'($urandom_range(0, 1));
            phase_wrap = w;
            dn = 1'b0;
            if (act && (longint'(age) >= dmin) && w) begin
               if (cur == stop) begin
                  if (lp) begin
                     cur = start;
                     age = 1;
                  end else begin
                     act = 1'b0;
                     dn  = 1'b1;
                  end
               end else begin
                  cur = step_rule(cur, stp, stop);
                  age = 1;
               end
            end else begin
               age++;
            end
            tick();
         end
         phase_wrap = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_immediate_commit();
      test_commit_waits_wrap();
      test_one_shot_sweep();
      test_overflow_loop();
      test_accept_beats_step_then_reset();
      test_random_sweeps();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
